bmem_dp_clr: RTL and testbench

BMEM_DP_CLR -- requirements
Module: bmem_dp_clr

---
 rtl/bmem_dp_clr.sv | 148 ++++++++++++++
 tb/tb_bmem_dp_clr.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_dp_clr.sv
// Purpose: dual-port block memory (port 1 read/write, port 2 read-only) with a
//          sweep that writes INIT_VAL into every word, started by reset or clr.
// Latency: read data + vld appear 1 cycle after re (2 cycles when OUT_REG=1).
// Backpressure: none; requests are dropped while busy (and in the clr cycle).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr / busy          start a clear sweep / sweep in progress
//   we, addr1, din      port 1 write
//   re1, addr1 -> dout1, vld1   port 1 read
//   re2, addr2 -> dout2, vld2   port 2 read
module bmem_dp_clr #(
  parameter int            DW       = 49,
  parameter int            AW       = 9,
  parameter int            RD_MODE  = 0,
  parameter int            OUT_REG  = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  input  logic          we,
  input  logic          re1,
  input  logic          re2,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2,
  output logic          vld1,
  output logic          vld2
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic          cnt_last;
  logic          go;

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] rd1_nxt, rd2_nxt;
  logic [DW-1:0] rd1_q, rd2_q;
  logic          rv1_q, rv2_q;

  // Terminal compare keeps cnt from ever wrapping past the last word.
  assign cnt_last = (cnt == {AW{1'b1}});

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt_last) state_nxt = IDLE;
      IDLE:    if (clr)      state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // go marks cycles whose read results are allowed to advance: the next cycle
  // is still IDLE. Reads in the clr cycle, and results still in flight when a
  // sweep begins, are dropped so vld never overlaps busy.
  always_comb begin
    busy = (state == CLEAR);
    go   = (state == IDLE) && !clr;
  end

  // Sweep address; held at 0 outside CLEAR so every sweep starts at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (state == CLEAR)  cnt <= cnt_last ? '0 : cnt + 1'b1;
    else                      cnt <= '0;
  end

  // Storage is never reset; the sweep that follows reset initialises it.
  always_ff @(posedge clk) begin
    if (busy)    mem[cnt]   <= INIT_VAL;
    else if (we) mem[addr1] <= din;
  end

  // Collision handling: write-first forwards din, read-first returns the
  // array contents sampled before this edge's write lands.
  always_comb begin
    rd1_nxt = mem[addr1];
    rd2_nxt = mem[addr2];
    if (RD_MODE != 0 && we)                    rd1_nxt = din;
    if (RD_MODE != 0 && we && addr2 == addr1)  rd2_nxt = din;
  end

  // First read stage: data holds when no new result is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
      rv1_q <= 1'b0;
      rv2_q <= 1'b0;
    end else begin
      rv1_q <= go && re1;
      rv2_q <= go && re2;
      if (go && re1) rd1_q <= rd1_nxt;
      if (go && re2) rd2_q <= rd2_nxt;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] o1_q, o2_q;
      logic          ov1_q, ov2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o1_q  <= '0;
          o2_q  <= '0;
          ov1_q <= 1'b0;
          ov2_q <= 1'b0;
        end else begin
          ov1_q <= go && rv1_q;
          ov2_q <= go && rv2_q;
          if (go && rv1_q) o1_q <= rd1_q;
          if (go && rv2_q) o2_q <= rd2_q;
        end
      end

      assign dout1 = o1_q;
      assign dout2 = o2_q;
      assign vld1  = ov1_q;
      assign vld2  = ov2_q;
    end else begin : g_noreg
      assign dout1 = rd1_q;
      assign dout2 = rd2_q;
      assign vld1  = rv1_q;
      assign vld2  = rv2_q;
    end
  endgenerate

endmodule

// File: tb/tb_bmem_dp_clr.sv
// Bench for bmem_dp_clr: three instances (defaults; write-first with INIT_VAL
// 0x1FF; small DW=16/AW=4 with output register). Stimulus pushes expected
// read data and arrival cycle; a negedge monitor pops and compares on vld.
module tb_bmem_dp_clr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       clr_v, we_v, re1_v, re2_v;
  logic [2:0][8:0]  a1_v, a2_v;
  logic [2:0][48:0] din_v;
  wire  [2:0]       busy_v, vld1_v, vld2_v;
  wire  [48:0]      d1_0, d2_0, d1_1, d2_1;
  wire  [15:0]      d1_2, d2_2;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  bmem_dp_clr u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[0]), .busy(busy_v[0]),
    .we(we_v[0]), .re1(re1_v[0]), .re2(re2_v[0]),
    .addr1(a1_v[0]), .addr2(a2_v[0]), .din(din_v[0]),
    .dout1(d1_0), .dout2(d2_0), .vld1(vld1_v[0]), .vld2(vld2_v[0])
  );

  bmem_dp_clr #(.RD_MODE(1), .INIT_VAL(49'h1FF)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[1]), .busy(busy_v[1]),
    .we(we_v[1]), .re1(re1_v[1]), .re2(re2_v[1]),
    .addr1(a1_v[1]), .addr2(a2_v[1]), .din(din_v[1]),
    .dout1(d1_1), .dout2(d2_1), .vld1(vld1_v[1]), .vld2(vld2_v[1])
  );

  bmem_dp_clr #(.DW(16), .AW(4), .OUT_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[2]), .busy(busy_v[2]),
    .we(we_v[2]), .re1(re1_v[2]), .re2(re2_v[2]),
    .addr1(a1_v[2][3:0]), .addr2(a2_v[2][3:0]), .din(din_v[2][15:0]),
    .dout1(d1_2), .dout2(d2_2), .vld1(vld1_v[2]), .vld2(vld2_v[2])
  );

  typedef struct {
    logic [63:0] v;
    int          cyc;
  } exp_t;

  exp_t q [6][$];

  function automatic logic [63:0] dout(int d, int p);
    case (d)
      0:       return (p == 0) ? {15'b0, d1_0} : {15'b0, d2_0};
      1:       return (p == 0) ? {15'b0, d1_1} : {15'b0, d2_1};
      default: return (p == 0) ? {48'b0, d1_2} : {48'b0, d2_2};
    endcase
  endfunction

  function automatic logic vld(int d, int p);
    return (p == 0) ? vld1_v[d] : vld2_v[d];
  endfunction

  function automatic int lat(int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (vld(d, p)) begin
          if (q[d*2+p].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_vld u%0d port%0d: got vld=1 required vld=0 (cycle %0d)",
                     d, p + 1, cyc);
          end else begin
            exp_t e;
            e = q[d*2+p].pop_front();
            chk($sformatf("rd_data u%0d port%0d", d, p + 1), dout(d, p), e.v);
            chk($sformatf("rd_cycle u%0d port%0d", d, p + 1), 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(int d, bit w, bit r1, int a1, logic [48:0] wd, logic [63:0] e1,
                    bit r2, int a2, logic [63:0] e2);
    exp_t e;
    we_v[d]  = w;
    re1_v[d] = r1;
    re2_v[d] = r2;
    a1_v[d]  = 9'(a1);
    a2_v[d]  = 9'(a2);
    din_v[d] = wd;
    if (r1) begin e.v = e1; e.cyc = cyc + lat(d); q[d*2].push_back(e); end
    if (r2) begin e.v = e2; e.cyc = cyc + lat(d); q[d*2+1].push_back(e); end
    tick();
    we_v[d]  = 1'b0;
    re1_v[d] = 1'b0;
    re2_v[d] = 1'b0;
  endtask

  task automatic pulse_clr(int d);
    clr_v[d] = 1'b1;
    tick();
    clr_v[d] = 1'b0;
  endtask

  // Counts cycles with busy high, bounded. With poke set, a write plus reads
  // are attempted at busy cycle 100 and a second clr at busy cycle 200.
  task automatic sweep_len(int d, bit poke, output int n);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!busy_v[d]) break;
      n++;
      we_v[d] = 1'b0; re1_v[d] = 1'b0; re2_v[d] = 1'b0; clr_v[d] = 1'b0;
      if (poke && n == 100) begin
        we_v[d] = 1'b1; re1_v[d] = 1'b1; re2_v[d] = 1'b1;
        a1_v[d] = 9'd3; a2_v[d] = 9'd3; din_v[d] = 49'h55;
      end
      if (poke && n == 200) clr_v[d] = 1'b1;
    end
    tick();
    we_v[d] = 1'b0; re1_v[d] = 1'b0; re2_v[d] = 1'b0; clr_v[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1);
  end

  localparam logic [48:0] V = 49'h1_2345_6789_ABC;

  initial begin
    int n;
    logic [15:0] wr2 [16];
    clr_v = '0; we_v = '0; re1_v = '0; re2_v = '0;
    a1_v = '0; a2_v = '0; din_v = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_busy u%0d", d), 64'(busy_v[d]), 64'd1);
      chk($sformatf("rst_vld1 u%0d", d), 64'(vld1_v[d]), 64'd0);
      chk($sformatf("rst_vld2 u%0d", d), 64'(vld2_v[d]), 64'd0);
      chk($sformatf("rst_dout1 u%0d", d), dout(d, 0), 64'd0);
      chk($sformatf("rst_dout2 u%0d", d), dout(d, 1), 64'd0);
    end
    tick();
    rst_n = 1'b1;
    sweep_len(0, 1'b0, n);
    chk("reset_sweep_len u0", 64'(n), 64'd512);

    // Cleared contents after reset.
    op(0, 0, 1, 0,   '0, 64'h0,   1, 511, 64'h0);
    op(0, 0, 1, 100, '0, 64'h0,   1, 300, 64'h0);
    op(1, 0, 1, 0,   '0, 64'h1FF, 1, 511, 64'h1FF);
    op(2, 0, 1, 15,  '0, 64'h0,   1, 0,   64'h0);

    // Write then read on the next cycle, both ports.
    op(0, 1, 0, 5, V, 0, 0, 0, 0);
    op(0, 0, 1, 5, '0, 64'(V), 1, 5, 64'(V));
    repeat (3) tick();
    chk("hold dout1 u0", dout(0, 0), 64'(V));
    chk("hold dout2 u0", dout(0, 1), 64'(V));

    // Read-first collisions.
    op(0, 1, 0, 7, 49'hAA, 0, 0, 0, 0);
    op(0, 1, 1, 7, 49'hBB, 64'hAA, 1, 7, 64'hAA);
    op(0, 0, 1, 7, '0, 64'hBB, 1, 7, 64'hBB);
    op(0, 1, 0, 8, 49'hCC, 0, 1, 5, 64'(V));
    op(0, 0, 0, 0, '0, 0, 1, 8, 64'hCC);

    // Write-first collisions.
    op(1, 1, 0, 7, 49'hAA, 0, 0, 0, 0);
    op(1, 1, 1, 7, 49'hBB, 64'hBB, 1, 7, 64'hBB);
    op(1, 0, 1, 7, '0, 64'hBB, 1, 6, 64'h1FF);
    op(1, 1, 1, 9, 49'hDD, 64'hDD, 1, 6, 64'h1FF);

    // Clear sweep with a write/read attempt and a second clr inside it.
    pulse_clr(1);
    sweep_len(1, 1'b1, n);
    chk("clr_sweep_len u1", 64'(n), 64'd512);
    for (int i = 0; i < 512; i++)
      op(1, 0, 1, i, '0, 64'h1FF, 1, 511 - i, 64'h1FF);

    // Small instance: sweep length, latency 2, streaming.
    pulse_clr(2);
    sweep_len(2, 1'b0, n);
    chk("clr_sweep_len u2", 64'(n), 64'd16);
    for (int i = 0; i < 16; i++) begin
      wr2[i] = 16'h1000 + 16'(i) * 16'h0111;
      op(2, 1, 0, i, 49'(wr2[i]), 0, 0, 0, 0);
    end
    wr2[15] = 16'hBEEF;
    op(2, 1, 0, 15, 49'hBEEF, 0, 0, 0, 0);
    op(2, 0, 0, 0, '0, 0, 1, 15, 64'hBEEF);
    for (int i = 0; i < 16; i++)
      op(2, 0, 1, i, '0, 64'(wr2[i]), 0, 0, 0);
    repeat (3) tick();

    // Reset mid-sweep on u0, with an in-flight read on u2.
    pulse_clr(0);
    repeat (198) tick();
    re1_v[2] = 1'b1;
    a1_v[2]  = 9'd2;
    tick();
    re1_v[2] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort busy u0", 64'(busy_v[0]), 64'd1);
    chk("abort dout1 u0", dout(0, 0), 64'd0);
    chk("abort dout2 u0", dout(0, 1), 64'd0);
    chk("abort dout1 u2", dout(2, 0), 64'd0);
    chk("abort vld1 u2", 64'(vld1_v[2]), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    sweep_len(0, 1'b0, n);
    chk("abort_sweep_len u0", 64'(n), 64'd512);
    op(0, 0, 1, 5, '0, 64'h0, 1, 7, 64'h0);

    repeat (4) tick();
    for (int i = 0; i < 6; i++)
      chk($sformatf("pending_results u%0d port%0d", i / 2, i % 2 + 1), 64'(q[i].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
